// File: rtl/pool_window_scheduler_if.sv
// Control/address bundle between the pooling-layer controller and the window scheduler.
// The master drives start/in_valid, and the slave (the scheduler) returns addresses and window flags.
interface pool_window_scheduler_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              in_valid;
  logic              clk_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              window_valid;
  logic [ADDR_W-1:0] out_row;
  logic [ADDR_W-1:0] out_col;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, in_valid,
    input  clk_en, wr_addr, rd_addr, window_valid, out_row, out_col, busy, frame_done
  );

  modport slave (
    input  start, in_valid,
    output clk_en, wr_addr, rd_addr, window_valid, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/pool_window_scheduler.sv
// Frame sequencer for the line-buffer/max-pool datapath. It tracks the raster position and
// flags stride-aligned complete windows with their output coordinates.
module pool_window_scheduler #(
  parameter int IMAGE_SIZE  = 28,
  parameter int FILTER_SIZE = 2,
  parameter int STRIDE      = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pool_window_scheduler_if.slave bus
);
  localparam int ADDR_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int PH_W   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(IMAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] FS_M1 = ADDR_W'(FILTER_SIZE - 1);
  localparam logic [ADDR_W-1:0] FS_M2 = ADDR_W'((FILTER_SIZE >= 2) ? FILTER_SIZE - 2 : 0);
  localparam logic [PH_W-1:0]   S_M1  = PH_W'(STRIDE - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] row_reg, col_reg;
  logic [PH_W-1:0]   row_ph_reg, col_ph_reg;
  logic [ADDR_W-1:0] out_row_cnt_reg, out_col_cnt_reg;
  logic [ADDR_W-1:0] out_row_reg, out_col_reg;
  logic              window_valid_reg, frame_done_reg, busy_reg;

  logic [ADDR_W-1:0] row_next, col_next, out_row_cnt_next, out_col_cnt_next;
  logic [PH_W-1:0]   row_ph_next, col_ph_next;
  logic              accept, col_last, row_last, col_hit, row_hit, hit;

  assign accept   = bus.in_valid & ((state_reg == FILL) | (state_reg == RUN));
  assign col_last = (col_reg == LAST);
  assign row_last = (row_reg == LAST);
  assign col_hit  = (col_reg >= FS_M1) && (col_ph_reg == '0);
  assign row_hit  = (row_reg >= FS_M1) && (row_ph_reg == '0);
  assign hit      = col_hit & row_hit;

  assign bus.clk_en       = accept;
  assign bus.wr_addr      = col_reg;
  assign bus.rd_addr      = col_reg;
  assign bus.window_valid = window_valid_reg;
  assign bus.out_row      = out_row_reg;
  assign bus.out_col      = out_col_reg;
  assign bus.busy         = busy_reg;
  assign bus.frame_done   = frame_done_reg;

  // Phases stay at zero until the position reaches FILTER_SIZE-1, then count modulo STRIDE.
  always_comb begin
    col_next         = col_last ? '0 : col_reg + 1'b1;
    col_ph_next      = (col_last || (col_reg < FS_M1) || (col_ph_reg == S_M1)) ? '0
                                                                               : col_ph_reg + 1'b1;
    out_col_cnt_next = col_last ? '0 : (col_hit ? out_col_cnt_reg + 1'b1 : out_col_cnt_reg);
    row_next         = row_reg;
    row_ph_next      = row_ph_reg;
    out_row_cnt_next = out_row_cnt_reg;
    if (col_last) begin
      row_next         = row_last ? '0 : row_reg + 1'b1;
      row_ph_next      = (row_last || (row_reg < FS_M1) || (row_ph_reg == S_M1)) ? '0
                                                                                 : row_ph_reg + 1'b1;
      out_row_cnt_next = row_last ? '0 : (row_hit ? out_row_cnt_reg + 1'b1 : out_row_cnt_reg);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      row_reg          <= '0;
      col_reg          <= '0;
      row_ph_reg       <= '0;
      col_ph_reg       <= '0;
      out_row_cnt_reg  <= '0;
      out_col_cnt_reg  <= '0;
      out_row_reg      <= '0;
      out_col_reg      <= '0;
      window_valid_reg <= 1'b0;
      frame_done_reg   <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          window_valid_reg <= 1'b0;
          frame_done_reg   <= 1'b0;
          if (bus.start) begin
            state_reg       <= (FILTER_SIZE == 1) ? RUN : FILL;
            busy_reg        <= 1'b1;
            row_reg         <= '0;
            col_reg         <= '0;
            row_ph_reg      <= '0;
            col_ph_reg      <= '0;
            out_row_cnt_reg <= '0;
            out_col_cnt_reg <= '0;
          end
        end
        FILL, RUN: begin
          window_valid_reg <= accept & hit;
          frame_done_reg   <= 1'b0;
          if (accept) begin
            row_reg         <= row_next;
            col_reg         <= col_next;
            row_ph_reg      <= row_ph_next;
            col_ph_reg      <= col_ph_next;
            out_row_cnt_reg <= out_row_cnt_next;
            out_col_cnt_reg <= out_col_cnt_next;
            if (hit) begin
              out_row_reg <= out_row_cnt_reg;
              out_col_reg <= out_col_cnt_reg;
            end
            // FILL ends once the first FILTER_SIZE-1 rows sit in the line buffers.
            if (state_reg == FILL && col_last && row_reg == FS_M2)
              state_reg <= RUN;
            if (state_reg == RUN && col_last && row_last) begin
              state_reg      <= DONE;
              frame_done_reg <= 1'b1;
            end
          end
        end
        DONE: begin
          state_reg        <= IDLE;
          busy_reg         <= 1'b0;
          window_valid_reg <= 1'b0;
          frame_done_reg   <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pool_window_scheduler.sv
// Directed bench: three scheduler configurations (4/2/2, 4/2/1, 5/2/2). Each frame's windows are
// logged as accept_index*100 + out_row*10 + out_col and compared against hand-computed tables.
module tb_pool_window_scheduler;
  logic clk;
  logic rst_n;
  logic [2:0] start_s;
  logic [2:0] inv_s;

  pool_window_scheduler_if #(.ADDR_W(2)) if_a ();
  pool_window_scheduler_if #(.ADDR_W(2)) if_b ();
  pool_window_scheduler_if #(.ADDR_W(3)) if_c ();

  assign if_a.start = start_s[0];
  assign if_a.in_valid = inv_s[0];
  assign if_b.start = start_s[1];
  assign if_b.in_valid = inv_s[1];
  assign if_c.start = start_s[2];
  assign if_c.in_valid = inv_s[2];

  pool_window_scheduler #(.IMAGE_SIZE(4), .FILTER_SIZE(2), .STRIDE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  pool_window_scheduler #(.IMAGE_SIZE(4), .FILTER_SIZE(2), .STRIDE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  pool_window_scheduler #(.IMAGE_SIZE(5), .FILTER_SIZE(2), .STRIDE(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  logic [2:0] wv, ce, busy, fd;
  logic [2:0][2:0] orow, ocol, wra, rda;
  assign wv   = {if_c.window_valid, if_b.window_valid, if_a.window_valid};
  assign ce   = {if_c.clk_en, if_b.clk_en, if_a.clk_en};
  assign busy = {if_c.busy, if_b.busy, if_a.busy};
  assign fd   = {if_c.frame_done, if_b.frame_done, if_a.frame_done};
  assign orow = {if_c.out_row, {1'b0, if_b.out_row}, {1'b0, if_a.out_row}};
  assign ocol = {if_c.out_col, {1'b0, if_b.out_col}, {1'b0, if_a.out_col}};
  assign wra  = {if_c.wr_addr, {1'b0, if_b.wr_addr}, {1'b0, if_a.wr_addr}};
  assign rda  = {if_c.rd_addr, {1'b0, if_b.rd_addr}, {1'b0, if_a.rd_addr}};

  int tests = 0;
  int failed = 0;
  int sel = 0;
  int acc, fd_cnt, fd_acc, fd_wv, stray, addr_err, ce_err;
  logic prev_ce;
  int win_q[$];
  int exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    win_q.delete();
    acc = 0; fd_cnt = 0; fd_acc = -1; fd_wv = 0; stray = 0;
    addr_err = 0; ce_err = 0; prev_ce = 1'b0;
  endtask

  // Window cycles must directly follow an accept cycle; the logged index is that accept.
  always @(negedge clk) begin
    if (wv[sel]) begin
      if (!prev_ce) stray++;
      win_q.push_back((acc - 1) * 100 + int'(orow[sel]) * 10 + int'(ocol[sel]));
    end
    if (fd[sel]) begin
      fd_cnt++;
      fd_acc = acc;
      fd_wv = int'(wv[sel]);
    end
    if (ce[sel]) acc++;
    prev_ce = ce[sel];
  end

  // mode: 0 contiguous, 1 alternating 1/0, 2 random bubbles.
  task automatic drive_frame(input int k, input int w, input int npix, input int mode,
                             input int mid_start, input int rst_at, input int start_in_done);
    int sent = 0;
    int cyc = 0;
    logic v;
    sel = k;
    clear_mon();
    @(posedge clk); #1;
    start_s[k] = 1'b1;
    inv_s[k] = 1'b1;
    @(negedge clk);
    chk_eq("start_cycle_ce", int'(ce[k]), 0);
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    while (sent < npix && cyc < 400) begin
      if (rst_at > 0 && sent == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk_eq("rst_window_valid", int'(wv[k]), 0);
        chk_eq("rst_frame_done", int'(fd[k]), 0);
        chk_eq("rst_busy", int'(busy[k]), 0);
        chk_eq("rst_out_row", int'(orow[k]), 0);
        chk_eq("rst_out_col", int'(ocol[k]), 0);
        chk_eq("rst_wr_addr", int'(wra[k]), 0);
        chk_eq("rst_clk_en", int'(ce[k]), 0);
        inv_s[k] = 1'b0;
        $display("[TB] frame dut=%0d reset after %0d accepts", k, sent);
        return;
      end
      case (mode)
        1: v = (cyc % 2 == 0);
        2: v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      inv_s[k] = v;
      start_s[k] = (mid_start != 0 && sent == 9);
      @(negedge clk);
      if (cyc == 0) chk_eq("busy_after_start", int'(busy[k]), 1);
      if (int'(wra[k]) != sent % w || int'(rda[k]) != sent % w) addr_err++;
      if (ce[k] != v) ce_err++;
      if (v) sent++;
      cyc++;
      @(posedge clk); #1;
    end
    chk_eq("pixels_sent", sent, npix);
    inv_s[k] = 1'b0;
    start_s[k] = (start_in_done != 0);
    @(negedge clk);
    chk_eq("busy_in_done", int'(busy[k]), 1);
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    @(negedge clk);
    chk_eq("busy_after_done", int'(busy[k]), 0);
    chk_eq("frame_done_one_cycle", int'(fd[k]), 0);
    $display("[TB] frame dut=%0d mode=%0d accepts=%0d windows=%0d frame_done_at=%0d",
             k, mode, acc, win_q.size(), fd_acc);
  endtask

  task automatic check_frame(input int npix, input int exp_fd_wv);
    chk_eq("window_count", win_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < win_q.size(); i++)
      chk_eq($sformatf("window_%0d", i), win_q[i], exp_q[i]);
    chk_eq("stray_window_valid", stray, 0);
    chk_eq("frame_done_count", fd_cnt, 1);
    chk_eq("frame_done_accepts", fd_acc, npix);
    chk_eq("frame_done_with_last_window", fd_wv, exp_fd_wv);
    chk_eq("address_errors", addr_err, 0);
    chk_eq("clk_en_errors", ce_err, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start_s = '0;
    inv_s = 3'b001;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_window_valid", int'(wv[0]), 0);
    chk_eq("reset_frame_done", int'(fd[0]), 0);
    chk_eq("reset_busy", int'(busy[0]), 0);
    chk_eq("reset_out_row", int'(orow[0]), 0);
    chk_eq("reset_out_col", int'(ocol[0]), 0);
    chk_eq("reset_wr_addr", int'(wra[0]), 0);
    chk_eq("reset_rd_addr", int'(rda[0]), 0);
    chk_eq("reset_clk_en", int'(ce[0]), 0);
    inv_s = '0;
    rst_n = 1'b1;

    // 4x4, filter 2, stride 2, contiguous.
    drive_frame(0, 4, 16, 0, 0, 0, 0);
    exp_q = '{500, 701, 1310, 1511};
    check_frame(16, 1);

    // 4x4, stride 1: nine windows.
    drive_frame(1, 4, 16, 0, 0, 0, 0);
    exp_q = '{500, 601, 702, 910, 1011, 1112, 1320, 1421, 1522};
    check_frame(16, 1);

    // Alternating bubbles, then random bubbles with a start pulse mid-frame.
    drive_frame(0, 4, 16, 1, 0, 0, 0);
    exp_q = '{500, 701, 1310, 1511};
    check_frame(16, 1);
    drive_frame(0, 4, 16, 2, 1, 0, 0);
    check_frame(16, 1);

    // 5x5 non-divisible: column 4 and row 4 produce no windows.
    drive_frame(2, 5, 25, 0, 0, 0, 0);
    exp_q = '{600, 801, 1610, 1811};
    check_frame(25, 0);

    // Reset after 7 accepts, then nothing must come out.
    drive_frame(0, 4, 16, 0, 0, 7, 0);
    clear_mon();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_eq("post_reset_windows", win_q.size(), 0);
    chk_eq("post_reset_frame_done", fd_cnt, 0);
    chk_eq("post_reset_busy", int'(busy[0]), 0);

    drive_frame(0, 4, 16, 0, 0, 0, 0);
    exp_q = '{500, 701, 1310, 1511};
    check_frame(16, 1);

    // Back-to-back: start held in DONE is ignored, the next start begins frame 2.
    drive_frame(0, 4, 16, 0, 0, 0, 1);
    check_frame(16, 1);
    drive_frame(0, 4, 16, 0, 0, 0, 0);
    check_frame(16, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
